// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - shared types and constants for the RPN operand-stack controller
package rpn_pkg;

    localparam int OPCODE_W = 3;

    localparam logic [2:0] STATUS_IDLE      = 3'd0;
    localparam logic [2:0] STATUS_ISSUE     = 3'd1;
    localparam logic [2:0] STATUS_WAIT      = 3'd2;
    localparam logic [2:0] STATUS_WRITEBACK = 3'd3;
    localparam logic [2:0] STATUS_ERROR     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = STATUS_IDLE,
        ST_ISSUE     = STATUS_ISSUE,
        ST_WAIT      = STATUS_WAIT,
        ST_WRITEBACK = STATUS_WRITEBACK,
        ST_ERROR     = STATUS_ERROR
    } rpn_state_t;

endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// rtl/rpn_stack_ctrl_if.sv - start/done handshake between the stack controller and the ALU
interface rpn_stack_ctrl_if #(
    parameter int WIDTH = 16
);
    import rpn_pkg::*;

    logic                AluStart;
    logic [WIDTH-1:0]    AluOpA;
    logic [WIDTH-1:0]    AluOpB;
    logic [OPCODE_W-1:0] AluOpCode;
    logic                AluDone;
    logic [WIDTH-1:0]    AluResult;

    modport master (
        output AluStart, AluOpA, AluOpB, AluOpCode,
        input  AluDone, AluResult
    );

    modport slave (
        input  AluStart, AluOpA, AluOpB, AluOpCode,
        output AluDone, AluResult
    );

endinterface

// File: rtl/rpn_stack_regfile.sv
// rtl/rpn_stack_regfile.sv - DEPTH x WIDTH operand registers with fill pointer
module rpn_stack_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push_en,
    input  logic [WIDTH-1:0] push_data,
    input  logic             replace_en,
    input  logic [WIDTH-1:0] replace_data,
    output logic [PW-1:0]    depth,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] second
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    cnt;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    second_idx;

    // Indices are only meaningful when the caller guards on depth.
    assign push_idx   = AW'(cnt);
    assign top_idx    = AW'(cnt - PW'(1));
    assign second_idx = AW'(cnt - PW'(2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_en) begin
            mem[push_idx] <= push_data;
            cnt           <= cnt + PW'(1);
        end else if (replace_en) begin
            mem[second_idx] <= replace_data;
            cnt             <= cnt - PW'(1);
        end
    end

    assign depth  = cnt;
    assign top    = (cnt == '0)      ? '0 : mem[top_idx];
    assign second = (cnt < PW'(2))   ? '0 : mem[second_idx];

endmodule

// File: rtl/rpn_stack_ctrl.sv
// rtl/rpn_stack_ctrl.sv - RPN operand stack FSM driving a multi-cycle ALU via start/done
module rpn_stack_ctrl
    import rpn_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         PushPulse,
    input  logic [WIDTH-1:0]             DataIn,
    input  logic                         OpPulse,
    input  logic [OPCODE_W-1:0]          OpCodeIn,
    input  logic                         ClearPulse,
    rpn_stack_ctrl_if.master             alu,
    output logic [WIDTH-1:0]             Top,
    output logic [$clog2(DEPTH+1)-1:0]   Depth,
    output logic                         Busy,
    output logic                         Err,
    output logic [2:0]                   Status
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    rpn_state_t          state, state_n;
    logic [CW-1:0]       tmo_cnt;
    logic [WIDTH-1:0]    op_a, op_b, res_q;
    logic [OPCODE_W-1:0] opcode_q;
    logic [WIDTH-1:0]    second;
    logic                clear, push_en, replace_en, latch_op, latch_res, cnt_clr, cnt_inc;

    rpn_stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_regfile (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .push_en      (push_en),
        .push_data    (DataIn),
        .replace_en   (replace_en),
        .replace_data (res_q),
        .depth        (Depth),
        .top          (Top),
        .second       (second)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            tmo_cnt  <= '0;
            op_a     <= '0;
            op_b     <= '0;
            opcode_q <= '0;
            res_q    <= '0;
        end else begin
            state <= state_n;
            if (cnt_clr)        tmo_cnt <= '0;
            else if (cnt_inc)   tmo_cnt <= tmo_cnt + CW'(1);
            if (latch_op) begin
                op_a     <= second;
                op_b     <= Top;
                opcode_q <= OpCodeIn;
            end
            if (latch_res) res_q <= alu.AluResult;
        end
    end

    always_comb begin
        state_n    = state;
        clear      = 1'b0;
        push_en    = 1'b0;
        replace_en = 1'b0;
        latch_op   = 1'b0;
        latch_res  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        if (ClearPulse) begin
            clear   = 1'b1;
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    // An op in the same cycle as a push takes precedence; the push is lost.
                    if (OpPulse) begin
                        if (Depth >= PW'(2)) begin
                            latch_op = 1'b1;
                            state_n  = ST_ISSUE;
                        end else begin
                            state_n  = ST_ERROR;
                        end
                    end else if (PushPulse) begin
                        if (Depth < PW'(DEPTH)) push_en = 1'b1;
                        else                    state_n = ST_ERROR;
                    end
                end
                ST_ISSUE: begin
                    cnt_clr = 1'b1;
                    state_n = ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu.AluDone) begin
                        latch_res = 1'b1;
                        state_n   = ST_WRITEBACK;
                    end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                        state_n   = ST_ERROR;
                    end else begin
                        cnt_inc   = 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    replace_en = 1'b1;
                    state_n    = ST_IDLE;
                end
                ST_ERROR: state_n = ST_ERROR;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    assign alu.AluStart  = (state == ST_ISSUE);
    assign alu.AluOpA    = op_a;
    assign alu.AluOpB    = op_b;
    assign alu.AluOpCode = opcode_q;
    assign Busy          = (state != ST_IDLE);
    assign Err           = (state == ST_ERROR);
    assign Status        = state;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// tb/tb_rpn_stack_ctrl.sv - randomized self-checking bench with a queue-based stack model
module tb_rpn_stack_ctrl;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic              PushPulse, OpPulse, ClearPulse;
    logic [WIDTH-1:0]  DataIn;
    logic [2:0]        OpCodeIn;
    logic [WIDTH-1:0]  Top;
    logic [2:0]        Depth;
    logic              Busy, Err;
    logic [2:0]        Status;

    rpn_stack_ctrl_if #(.WIDTH(WIDTH)) alu_if ();

    rpn_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .PushPulse  (PushPulse),
        .DataIn     (DataIn),
        .OpPulse    (OpPulse),
        .OpCodeIn   (OpCodeIn),
        .ClearPulse (ClearPulse),
        .alu        (alu_if.master),
        .Top        (Top),
        .Depth      (Depth),
        .Busy       (Busy),
        .Err        (Err),
        .Status     (Status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int start_cnt = 0;

    always @(posedge clk) if (alu_if.AluStart === 1'b1) start_cnt <= start_cnt + 1;

    int unsigned mstack[$];
    bit          merr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_depth"}, 32'(Depth), mstack.size());
        check({tag, "_top"}, 32'(Top), (mstack.size() == 0) ? 0 : mstack[mstack.size()-1]);
        check({tag, "_err"}, 32'(Err), 32'(merr));
        check({tag, "_busy"}, 32'(Busy), 32'(merr));
        check({tag, "_status"}, 32'(Status), merr ? 4 : 0);
    endtask

    task automatic do_push(input logic [WIDTH-1:0] v);
        PushPulse = 1'b1;
        DataIn    = v;
        tick();
        PushPulse = 1'b0;
        if (!merr) begin
            if (mstack.size() < DEPTH) mstack.push_back(v);
            else                       merr = 1'b1;
        end
        check_model("push");
    endtask

    task automatic do_clear();
        ClearPulse = 1'b1;
        tick();
        ClearPulse = 1'b0;
        mstack.delete();
        merr = 1'b0;
        check_model("clear");
    endtask

    task automatic do_op(input logic [2:0] opc, input int delay, input logic [WIDTH-1:0] res,
                         input bit with_push, input logic [WIDTH-1:0] pv);
        int unsigned a, b;
        int s0;
        s0       = start_cnt;
        OpPulse  = 1'b1;
        OpCodeIn = opc;
        if (with_push) begin
            PushPulse = 1'b1;
            DataIn    = pv;
        end
        tick();
        OpPulse   = 1'b0;
        PushPulse = 1'b0;
        if (merr || mstack.size() < 2) begin
            merr = 1'b1;
            check("op_rej_start", 32'(alu_if.AluStart), 0);
            tick();
            check("op_rej_no_start", start_cnt - s0, 0);
            check_model("op_rej");
            return;
        end
        a = mstack[mstack.size()-2];
        b = mstack[mstack.size()-1];
        check("issue_status", 32'(Status), 1);
        check("issue_start", 32'(alu_if.AluStart), 1);
        check("issue_opa", 32'(alu_if.AluOpA), a);
        check("issue_opb", 32'(alu_if.AluOpB), b);
        check("issue_opc", 32'(alu_if.AluOpCode), 32'(opc));
        tick();
        check("wait_status", 32'(Status), 2);
        check("wait_start_low", 32'(alu_if.AluStart), 0);
        check("start_once", start_cnt - s0, 1);
        repeat (delay) tick();
        check("wait_opa_held", 32'(alu_if.AluOpA), a);
        check("wait_opb_held", 32'(alu_if.AluOpB), b);
        alu_if.AluDone   = 1'b1;
        alu_if.AluResult = res;
        tick();
        alu_if.AluDone = 1'b0;
        check("wb_status", 32'(Status), 3);
        tick();
        void'(mstack.pop_back());
        void'(mstack.pop_back());
        mstack.push_back(res);
        check_model("op_done");
    endtask

    initial begin
        logic [WIDTH-1:0] x, y;
        int r;
        reset = 1'b0;
        PushPulse = 1'b0; OpPulse = 1'b0; ClearPulse = 1'b0;
        DataIn = '0; OpCodeIn = '0;
        alu_if.AluDone = 1'b0; alu_if.AluResult = '0;
        merr = 1'b0;
        tick(); tick();
        check("rst_opa", 32'(alu_if.AluOpA), 0);
        check("rst_start", 32'(alu_if.AluStart), 0);
        check_model("rst");
        reset = 1'b1;
        tick();

        // Basic 5 3 + -> 8
        do_push(16'd5);
        do_push(16'd3);
        do_op(3'd0, 2, 16'd8, 1'b0, '0);
        check("basic_top", 32'(Top), 8);
        check("basic_depth", 32'(Depth), 1);

        // Overflow
        do_clear();
        for (int i = 1; i <= 4; i++) do_push(WIDTH'(16'h100 + i));
        do_push(16'hdead);
        check("ovf_status", 32'(Status), 4);
        check("ovf_top", 32'(Top), 32'h104);
        do_clear();

        // Underflow
        do_push(16'd7);
        do_op(3'd2, 0, 16'd1, 1'b0, '0);
        check("unf_err", 32'(Err), 1);
        do_clear();

        // Simultaneous push and op: op wins
        do_push(16'd20);
        do_push(16'd30);
        do_op(3'd5, 0, 16'd50, 1'b1, 16'h7777);
        check("pushop_depth", 32'(Depth), 1);
        do_clear();

        // Timeout, ignored push in WAIT, late AluDone ignored
        x = 16'h1111; y = 16'h2222;
        do_push(x);
        do_push(y);
        OpPulse = 1'b1; OpCodeIn = 3'd1;
        tick();
        OpPulse = 1'b0;
        check("tmo_issue", 32'(Status), 1);
        tick();
        check("tmo_wait1", 32'(Status), 2);
        PushPulse = 1'b1; DataIn = 16'h3333;
        tick();
        PushPulse = 1'b0;
        check("wait_push_ignored", 32'(Depth), 2);
        repeat (TIMEOUT - 2) tick();
        check("tmo_last_wait", 32'(Status), 2);
        tick();
        check("tmo_error", 32'(Status), 4);
        merr = 1'b1;
        alu_if.AluDone = 1'b1; alu_if.AluResult = 16'hbeef;
        tick();
        alu_if.AluDone = 1'b0;
        tick();
        check_model("late_done");
        do_clear();

        // Async reset during WAIT
        do_push(16'd9);
        do_push(16'd4);
        OpPulse = 1'b1; OpCodeIn = 3'd3;
        tick();
        OpPulse = 1'b0;
        tick();
        check("arst_pre_wait", 32'(Status), 2);
        #2 reset = 1'b0;
        #1;
        check("arst_status", 32'(Status), 0);
        check("arst_depth", 32'(Depth), 0);
        check("arst_top", 32'(Top), 0);
        check("arst_busy", 32'(Busy), 0);
        check("arst_opa", 32'(alu_if.AluOpA), 0);
        check("arst_opb", 32'(alu_if.AluOpB), 0);
        check("arst_opc", 32'(alu_if.AluOpCode), 0);
        @(negedge clk);
        reset = 1'b1;
        mstack.delete();
        merr = 1'b0;
        tick();
        check_model("arst_after");

        // Randomized traffic against the model
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 11);
            if (r <= 4)       do_push(WIDTH'($urandom));
            else if (r <= 8)  do_op(3'($urandom), $urandom_range(0, 6), WIDTH'($urandom), 1'b0, '0);
            else if (r == 9)  do_op(3'($urandom), $urandom_range(0, 3), WIDTH'($urandom), 1'b1, WIDTH'($urandom));
            else if (merr || r == 11) do_clear();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/rpn_stack_ctrl.md
# rpn_stack_ctrl

Operand-stack controller for the reverse-Polish calculator. It holds a small stack of operands and turns operator entries into start/done transactions on the shared multi-cycle ALU. On completion it writes the result back on top of the stack. It sits between the debounced keypad pulse logic and the ALU datapath, and feeds the display path through `Top`/`Depth`/`Status`.

## Interface
- `WIDTH`, 16: operand/result width.
- `DEPTH`, 4: stack entries (≥2).
- `TIMEOUT`, 255: max cycles waiting for `AluDone` before error.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `PushPulse` in 1: one-cycle request to push `DataIn`.
- `DataIn` in WIDTH: operand to push.
- `OpPulse` in 1: one-cycle request to execute `OpCodeIn`.
- `OpCodeIn` in 3: operator code, passed through unchanged to the ALU.
- `ClearPulse` in 1: one-cycle synchronous clear of stack and error.
- `AluStart` out 1: one-cycle start strobe to the ALU.
- `AluOpA` out WIDTH: second-from-top entry, held stable from ISSUE through WAIT.
- `AluOpB` out WIDTH: top entry, held stable from ISSUE through WAIT.
- `AluOpCode` out 3: latched opcode.
- `AluDone` in 1: ALU result valid. Sampled only in WAIT.
- `AluResult` in WIDTH: ALU result.
- `Top` out WIDTH: `stack[Depth-1]`, or 0 when empty.
- `Depth` out $clog2(DEPTH+1): number of valid entries.
- `Busy` out 1: high in every state except IDLE.
- `Err` out 1: high in ERROR.
- `Status` out 3: state code. IDLE=0, ISSUE=1, WAIT=2, WRITEBACK=3, ERROR=4.

## Operation
States and transitions:
- **IDLE**
  - `OpPulse` with `Depth`≥2: latch A=`stack[Depth-2]`, B=`stack[Depth-1]`, opcode; go to ISSUE.
  - `OpPulse` with `Depth`<2: go to ERROR (underflow).
  - `PushPulse` with `Depth`<DEPTH: write `stack[Depth]`=`DataIn`, `Depth`+1; stay in IDLE.
  - `PushPulse` with `Depth`==DEPTH: go to ERROR (overflow); stack unchanged.
  - `PushPulse` and `OpPulse` in the same cycle: the op wins and the push is dropped.
- **ISSUE**: `AluStart`=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- **WAIT**
  - `AluDone`=1: latch `AluResult`; go to WRITEBACK.
  - Counter reaches TIMEOUT: go to ERROR.
- **WRITEBACK**: `stack[Depth-2]`=result, `Depth`−1 (net pop two, push one); go to IDLE.
- **ERROR**: hold the stack and `Depth`; stay until `ClearPulse`.

General rules:
- `PushPulse`/`OpPulse` outside IDLE are ignored, not queued.
- `ClearPulse` in any state, with priority over everything else: `Depth`=0, entries zeroed, go to IDLE next cycle. A late `AluDone` from an abandoned op is ignored, since it is only sampled in WAIT.
- Result is truncated to WIDTH. There is no arithmetic in this block.

## Timing
- Reset (asynchronous, active-low): state IDLE, `Depth`=0, all stack entries 0, `Top`=0, `AluStart`=0, `AluOpA`/`AluOpB`=0, `AluOpCode`=0, `Busy`=0, `Err`=0, `Status`=0, timeout counter 0.
- Reset mid-operation aborts immediately; the ALU must tolerate an abandoned start.
- Push: `PushPulse` in cycle n → `Top`/`Depth` updated in cycle n+1.
- Op sequence:
  - `OpPulse` in cycle n.
  - ISSUE in n+1, with `AluStart` high.
  - WAIT from n+2.
  - `AluDone` in cycle k → WRITEBACK in k+1 → IDLE with new `Top` in k+2.
  - Minimum op latency (`AluDone` in n+2) is 4 cycles.
- Timeout: ERROR is entered when `AluDone` has not been seen for TIMEOUT cycles in WAIT.
- All outputs are registered or decoded from registered state only. There is no input-to-output combinational path.

## Structure
- Shared package `rpn_pkg`:
  - state enum `rpn_state_t`
  - `Status` code constants
  - `OPCODE_W`=3
- Sub-module `rpn_stack_regfile`: DEPTH×WIDTH registers plus pointer, with push/replace-top-two ports. It holds no control logic.
- `rpn_stack_ctrl` owns the FSM, the operand/opcode latches and the timeout counter.

## Test plan
- Reset, then push 5, 3; `OpPulse` with opcode 0; `AluDone` with `AluResult`=8 three cycles after `AluStart` → `AluOpA`=5, `AluOpB`=3, single-cycle `AluStart`, final `Depth`=1, `Top`=8, `Busy` low.
- Push 4 values with DEPTH=4, then a fifth push → `Err`=1, `Status`=4, `Depth`=4, `Top`=4th value. `ClearPulse` → `Depth`=0, `Err`=0.
- `OpPulse` with `Depth`=1 → ERROR; `AluStart` never asserted.
- `PushPulse` and `OpPulse` together with `Depth`=2 → op executes; `Depth` goes 2→1, the pushed value is absent.
- No `AluDone` for 255 cycles in WAIT → ERROR. A later `AluDone` causes no change.
- Async `reset` low during WAIT → all outputs at reset values without waiting for a clock edge. `PushPulse` in WAIT → ignored, `Depth` unchanged.
